// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8:1 mux round-robin arbiter: FSM encoding,
// fixed requester/select sizes and small one-hot / pointer helpers.
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

    // A locked winner keeps the pointer so it stays first in the next scan.
    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] idx,
                                                  input logic             lock_bit);
        logic [SEL_W-1:0] p;
        if (lock_bit) begin
            p = idx;
        end else begin
            p = idx + 3'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping 7 -> 0. Rotate right by ptr, find first set, add ptr back.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot_s;
    logic [SEL_W-1:0] ffs_s;

    // Rotate so the pointer position lands on bit 0, then scan low to high.
    always_comb begin
        rot_s = N_REQ'({req, req} >> ptr);
        ffs_s = {SEL_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                ffs_s = SEL_W'(i);
            end else begin
                ffs_s = ffs_s;
            end
        end
        idx = ffs_s + ptr;
        any = |req;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 8:1 byte mux (IDLE->SEL->HOLD).
// Optional feature: define MUX8_ARB_LOCK_EN to add lock[7:0] burst priority.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
`ifdef MUX8_ARB_LOCK_EN
    input  logic [N_REQ-1:0]  lock,
`endif
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [DATA_W-1:0] mux_dout,
    output logic [N_REQ-1:0]  gnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_e            state_r,     state_nx_s;
    logic [SEL_W-1:0]  ptr_r,       ptr_nx_s;
    logic [SEL_W-1:0]  mux_sel_r,   mux_sel_nx_s;
    logic [N_REQ-1:0]  gnt_r,       gnt_nx_s;
    logic [DATA_W-1:0] out_data_r,  out_data_nx_s;
    logic              out_valid_r, out_valid_nx_s;
    logic              busy_r,      busy_nx_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              lock_bit_s;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

`ifdef MUX8_ARB_LOCK_EN
    assign lock_bit_s = lock[mux_sel_r];
`else
    assign lock_bit_s = 1'b0;
`endif

    // Next-state and next-output logic; mux_sel doubles as the latched winner.
    always_comb begin
        state_nx_s     = state_r;
        ptr_nx_s       = ptr_r;
        mux_sel_nx_s   = mux_sel_r;
        gnt_nx_s       = {N_REQ{1'b0}};
        out_data_nx_s  = out_data_r;
        out_valid_nx_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    mux_sel_nx_s = pick_idx_s;
                    state_nx_s   = SEL;
                end else begin
                    state_nx_s   = IDLE;
                end
            end
            SEL: begin
                // Capture and grant even if the winner already dropped req.
                out_data_nx_s  = mux_dout;
                out_valid_nx_s = 1'b1;
                gnt_nx_s       = onehot8(mux_sel_r);
                ptr_nx_s       = ptr_next(mux_sel_r, lock_bit_s);
                state_nx_s     = HOLD;
            end
            HOLD: begin
                if (out_valid_r && out_ready) begin
                    out_valid_nx_s = 1'b0;
                    state_nx_s     = IDLE;
                end else begin
                    state_nx_s     = HOLD;
                end
            end
            default: begin
                out_valid_nx_s = 1'b0;
                state_nx_s     = IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State and output registers; reset discards any in-flight byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {SEL_W{1'b0}};
            mux_sel_r   <= {SEL_W{1'b0}};
            gnt_r       <= {N_REQ{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ptr_r       <= ptr_nx_s;
            mux_sel_r   <= mux_sel_nx_s;
            gnt_r       <= gnt_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign mux_sel   = mux_sel_r;
    assign gnt       = gnt_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter against a scan-order reference model.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] mux_sel;
    logic [7:0] mux_dout;
    logic [7:0] gnt;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef MUX8_ARB_LOCK_EN
    logic [7:0] lock;
`endif

    logic [7:0] in_byte [8];
    int errors = 0;
    int checks = 0;
    int model_ptr = 0;
    int model_lock = 0;

    assign mux_dout = in_byte[mux_sel];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef MUX8_ARB_LOCK_EN
        .lock      (lock),
`endif
        .mux_sel   (mux_sel),
        .mux_dout  (mux_dout),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Reference: first requester at or after the pointer, wrapping 7 -> 0.
    function automatic int model_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic randomize_bytes();
        for (int i = 0; i < 8; i++) in_byte[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (mux_sel !== 3'd0 || gnt !== 8'h00 || out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%0d gnt=%h data=%h valid=%b busy=%b, want all zero", mux_sel, gnt, out_data, out_valid, busy);
        end
        rst = 1'b0;
        req = 8'h08;
        @(negedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prehold: valid=%b busy=%b, want 1 1", out_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mux_sel !== 3'd0 || gnt !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_midhold: sel=%0d gnt=%h valid=%b busy=%b data=%h, want all zero", mux_sel, gnt, out_valid, busy, out_data);
        end
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_gnt: gnt=%h busy=%b, want 00 0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        int order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        randomize_bytes();
        req = 8'hFF; out_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            exp = model_pick(req, model_ptr);
            checks++;
            if (exp != order[t]) begin
                errors++;
                $display("FAIL rr_model_order: model=%0d want %0d", exp, order[t]);
            end
            @(negedge clk);
            checks++;
            if (mux_sel !== 3'(exp) || gnt !== 8'h00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_sel: sel=%0d gnt=%h busy=%b, want sel=%0d gnt=00 busy=1", mux_sel, gnt, busy, exp);
            end
            @(negedge clk);
            checks++;
            if (gnt !== (8'h01 << exp) || out_valid !== 1'b1 || out_data !== in_byte[exp]) begin
                errors++;
                $display("FAIL rr_grant: gnt=%h valid=%b data=%h, want gnt=%h valid=1 data=%h", gnt, out_valid, out_data, 8'h01 << exp, in_byte[exp]);
            end
            @(negedge clk);
            checks++;
            if (gnt !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_release: gnt=%h valid=%b busy=%b, want 00 0 0", gnt, out_valid, busy);
            end
            model_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_single();
        in_byte[3] = 8'hA5;
        req = 8'h08; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mux_sel !== 3'd3 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL single_sel: sel=%0d gnt=%h, want 3 00", mux_sel, gnt);
        end
        req = 8'h00;
        @(negedge clk);
        checks++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1 || gnt !== 8'h08) begin
            errors++;
            $display("FAIL single_grant: data=%h valid=%b gnt=%h, want A5 1 08", out_data, out_valid, gnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL single_done: valid=%b busy=%b gnt=%h, want 0 0 00", out_valid, busy, gnt);
        end
        model_ptr = 4;
    endtask

    task automatic test_wrap();
        int exp;
        logic [7:0] tbl  [5] = '{8'h40, 8'h81, 8'h81, 8'h10, 8'h01};
        int         want [5] = '{6, 7, 0, 4, 0};
        randomize_bytes();
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            req = tbl[t];
            exp = model_pick(req, model_ptr);
            @(negedge clk);
            checks++;
            if (mux_sel !== 3'(want[t]) || exp != want[t]) begin
                errors++;
                $display("FAIL wrap_sel: sel=%0d model=%0d, want %0d", mux_sel, exp, want[t]);
            end
            @(negedge clk);
            checks++;
            if (gnt !== (8'h01 << want[t]) || out_data !== in_byte[want[t]]) begin
                errors++;
                $display("FAIL wrap_grant: gnt=%h data=%h, want %h %h", gnt, out_data, 8'h01 << want[t], in_byte[want[t]]);
            end
            @(negedge clk);
            model_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
    endtask

    task automatic test_backpressure();
        int exp;
        logic [7:0] cap;
        randomize_bytes();
        out_ready = 1'b0;
        req = 8'h24;
        exp = model_pick(req, model_ptr);
        @(negedge clk); @(negedge clk);
        cap = in_byte[exp];
        req = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_data !== cap || mux_sel !== 3'(exp) || gnt !== 8'h00 || out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: data=%h sel=%0d gnt=%h valid=%b busy=%b, want %h %0d 00 1 1", out_data, mux_sel, gnt, out_valid, busy, cap, exp);
            end
        end
        req = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mux_sel !== 3'(exp)) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b sel=%0d, want 0 0 %0d", out_valid, busy, mux_sel, exp);
        end
        model_ptr = (exp + 1) % 8;
    endtask

    task automatic test_random();
        int exp;
        int d;
        logic [7:0] pend = 8'h00;
        for (int t = 0; t < 40; t++) begin
            randomize_bytes();
            pend = pend | 8'($urandom_range(0, 255));
            if (pend == 8'h00) pend = 8'h80;
            req = pend;
            d = $urandom_range(0, 3);
            out_ready = (d == 0);
            exp = model_pick(pend, model_ptr);
            @(negedge clk);
            checks++;
            if (mux_sel !== 3'(exp)) begin
                errors++;
                $display("FAIL rand_sel: req=%h sel=%0d, want %0d", pend, mux_sel, exp);
            end
            @(negedge clk);
            checks++;
            if (gnt !== (8'h01 << exp) || out_data !== in_byte[exp] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_grant: gnt=%h data=%h valid=%b, want %h %h 1", gnt, out_data, out_valid, 8'h01 << exp, in_byte[exp]);
            end
            pend[exp] = 1'b0;
            req = pend;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                checks++;
                if (gnt !== 8'h00 || out_valid !== 1'b1 || out_data !== in_byte[exp]) begin
                    errors++;
                    $display("FAIL rand_stall: gnt=%h valid=%b data=%h, want 00 1 %h", gnt, out_valid, out_data, in_byte[exp]);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_done: valid=%b busy=%b, want 0 0", out_valid, busy);
            end
            model_ptr = (exp + 1) % 8;
        end
        req = 8'h00;
        @(negedge clk);
    endtask

`ifdef MUX8_ARB_LOCK_EN
    task automatic test_lock();
        int exp;
        logic [7:0] lk   [5] = '{8'h00, 8'h02, 8'h02, 8'h00, 8'h00};
        logic [7:0] rq   [5] = '{8'h01, 8'h06, 8'h06, 8'h06, 8'h06};
        int         want [5] = '{0, 1, 1, 1, 2};
        out_ready = 1'b1;
        model_ptr = model_pick(8'h01, model_ptr);
        model_ptr = 0;
        for (int t = 0; t < 5; t++) begin
            req = rq[t];
            lock = lk[t];
            exp = model_pick(req, model_ptr);
            @(negedge clk); @(negedge clk);
            checks++;
            if (gnt !== (8'h01 << want[t]) || exp != want[t]) begin
                errors++;
                $display("FAIL lock_grant: gnt=%h model=%0d, want idx %0d", gnt, exp, want[t]);
            end
            @(negedge clk);
            model_ptr = lock[exp] ? exp : (exp + 1) % 8;
        end
        req = 8'h00; lock = 8'h00;
    endtask
`endif

    initial begin
`ifdef MUX8_ARB_LOCK_EN
        lock = 8'h00;
`endif
        for (int i = 0; i < 8; i++) in_byte[i] = 8'h00;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_backpressure();
        test_random();
`ifdef MUX8_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
